// File: rtl/ipml_pfifo_pkg.sv
// Shared types and helpers for the ipml prefetch FIFO family.
package ipml_pfifo_pkg;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned v;
        int unsigned r;
        v = (value > 0) ? value - 1 : 0;
        r = 0;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    localparam int unsigned PFIFO_DEPTH_WIDTH = 10;
    localparam int unsigned DEPTH             = 1 << PFIFO_DEPTH_WIDTH;

    typedef logic [PFIFO_DEPTH_WIDTH:0] cnt_t;

    typedef enum logic [1:0] {
        STG_EMPTY = 2'd0,
        STG_ONE   = 2'd1,
        STG_TWO   = 2'd2
    } stg_state_t;

endpackage

// File: rtl/ipml_pfifo_out_stage.sv
// Two-entry valid/ready output register stage; entry 0 is always the head word.
module ipml_pfifo_out_stage
    import ipml_pfifo_pkg::*;
#(
    parameter int unsigned c_DATA_WIDTH = 32
)
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    data_in_valid,
    input  logic [c_DATA_WIDTH-1:0] data_in,
    input  logic                    data_out_ready,
    output logic [c_DATA_WIDTH-1:0] data_out,
    output logic                    data_out_valid,
    output logic [1:0]              occupancy
);

    stg_state_t              state_q, state_d;
    logic [c_DATA_WIDTH-1:0] d0_q, d0_d;
    logic [c_DATA_WIDTH-1:0] d1_q, d1_d;
    logic                    pop;

    assign pop = data_out_ready & (state_q != STG_EMPTY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= STG_EMPTY;
            d0_q    <= '0;
            d1_q    <= '0;
        end else begin
            state_q <= state_d;
            d0_q    <= d0_d;
            d1_q    <= d1_d;
        end
    end

    // The upstream issue logic never pushes into a full stage without a pop.
    always_comb begin
        state_d = state_q;
        d0_d    = d0_q;
        d1_d    = d1_q;
        if (clr) begin
            state_d = STG_EMPTY;
            d0_d    = '0;
            d1_d    = '0;
        end else begin
            case (state_q)
                STG_EMPTY: begin
                    if (data_in_valid) begin
                        d0_d    = data_in;
                        state_d = STG_ONE;
                    end
                end
                STG_ONE: begin
                    if (data_in_valid && pop) begin
                        d0_d = data_in;
                    end else if (data_in_valid) begin
                        d1_d    = data_in;
                        state_d = STG_TWO;
                    end else if (pop) begin
                        state_d = STG_EMPTY;
                    end
                end
                STG_TWO: begin
                    if (pop) begin
                        d0_d = d1_q;
                        if (data_in_valid) begin
                            d1_d = data_in;
                        end else begin
                            state_d = STG_ONE;
                        end
                    end
                end
                default: state_d = STG_EMPTY;
            endcase
        end
    end

    assign data_out       = d0_q;
    assign data_out_valid = (state_q != STG_EMPTY);
    assign occupancy      = (state_q == STG_TWO) ? 2'd2 :
                            (state_q == STG_ONE) ? 2'd1 : 2'd0;

endmodule

// File: rtl/ipml_sc_prefetch_fifo_v2_0.sv
// Single-clock FWFT FIFO: sync-read RAM feeding a 2-entry prefetch stage.
// Optional sticky overflow/underflow flags via `IPML_PFIFO_ERR_FLAG_EN.
module ipml_sc_prefetch_fifo_v2_0
    import ipml_pfifo_pkg::*;
#(
    parameter int unsigned c_DATA_WIDTH       = 32,
    parameter int unsigned c_DEPTH_WIDTH      = PFIFO_DEPTH_WIDTH,
    parameter int unsigned c_ALMOST_FULL_NUM  = (1 << c_DEPTH_WIDTH) - 4,
    parameter int unsigned c_ALMOST_EMPTY_NUM = 4
)
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic [c_DATA_WIDTH-1:0]  wr_data,
    input  logic                     wr_en,
    output logic                     wr_vld,
    output logic [c_DATA_WIDTH-1:0]  rd_data,
    input  logic                     rd_en,
    output logic                     rd_vld,
    output logic [c_DEPTH_WIDTH:0]   water_level,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int unsigned WORDS = 1 << c_DEPTH_WIDTH;
    localparam int unsigned PTR_W = clog2(WORDS);

    typedef logic [c_DEPTH_WIDTH:0] lvl_t;

    localparam lvl_t FULL_LVL = lvl_t'(WORDS);
    localparam lvl_t AF_LVL   = lvl_t'(c_ALMOST_FULL_NUM);
    localparam lvl_t AE_LVL   = lvl_t'(c_ALMOST_EMPTY_NUM);

    logic [c_DATA_WIDTH-1:0] mem [WORDS];
    logic [c_DATA_WIDTH-1:0] ram_q;
    logic [PTR_W-1:0]        wr_ptr, rd_ptr;
    lvl_t                    count_q, count_d;
    lvl_t                    ram_cnt_q, ram_cnt_d;
    logic                    inflight_q;
    logic                    af_q, ae_q;
    logic [1:0]              stg_occ;
    logic                    stg_vld;
    logic                    accept_wr, pop, room, rd_issue;

    // Full is decoded from the registered count, so a same-cycle pop never frees a slot.
    assign wr_vld    = (count_q != FULL_LVL);
    assign accept_wr = wr_en & wr_vld & ~flush;
    assign pop       = rd_en & stg_vld & ~flush;
    assign room      = ({1'b0, stg_occ} + {2'b00, inflight_q}) < 3'd2;
    assign rd_issue  = (ram_cnt_q != '0) & (room | pop) & ~flush;

    assign count_d   = count_q + lvl_t'(accept_wr) - lvl_t'(pop);
    assign ram_cnt_d = ram_cnt_q + lvl_t'(accept_wr) - lvl_t'(rd_issue);

    always_ff @(posedge clk) begin
        if (accept_wr) begin
            mem[wr_ptr] <= wr_data;
        end
        if (rd_issue) begin
            ram_q <= mem[rd_ptr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            ram_cnt_q  <= '0;
            inflight_q <= 1'b0;
            af_q       <= 1'b0;
            ae_q       <= 1'b1;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            ram_cnt_q  <= '0;
            inflight_q <= 1'b0;
            af_q       <= 1'b0;
            ae_q       <= 1'b1;
        end else begin
            if (accept_wr) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_issue) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count_q    <= count_d;
            ram_cnt_q  <= ram_cnt_d;
            inflight_q <= rd_issue;
            af_q       <= (count_d >= AF_LVL);
            ae_q       <= (count_d <= AE_LVL);
        end
    end

    // An in-flight read is dropped on flush because the stage clear dominates its load.
    ipml_pfifo_out_stage #(
        .c_DATA_WIDTH (c_DATA_WIDTH)
    ) u_out_stage (
        .clk            (clk),
        .rst_n          (rst_n),
        .clr            (flush),
        .data_in_valid  (inflight_q),
        .data_in        (ram_q),
        .data_out_ready (rd_en),
        .data_out       (rd_data),
        .data_out_valid (stg_vld),
        .occupancy      (stg_occ)
    );

    assign rd_vld       = stg_vld;
    assign water_level  = count_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;

`ifdef IPML_PFIFO_ERR_FLAG_EN
    logic ovf_q, unf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (flush) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (wr_en & ~wr_vld) begin
                ovf_q <= 1'b1;
            end
            if (rd_en & ~stg_vld) begin
                unf_q <= 1'b1;
            end
        end
    end

    assign overflow  = ovf_q;
    assign underflow = unf_q;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_ipml_sc_prefetch_fifo_v2_0.sv
// Randomized scoreboard bench for ipml_sc_prefetch_fifo_v2_0 with a queue-based reference.
module tb_ipml_sc_prefetch_fifo_v2_0;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned AF    = DEPTH - 4;
    localparam int unsigned AE    = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_en = 1'b0;
    logic          wr_vld;
    logic [DW-1:0] rd_data;
    logic          rd_en = 1'b0;
    logic          rd_vld;
    logic [AW:0]   water_level;
    logic          almost_full;
    logic          almost_empty;
    logic          overflow;
    logic          underflow;

    always #5 clk = ~clk;

    ipml_sc_prefetch_fifo_v2_0 #(
        .c_DATA_WIDTH       (DW),
        .c_DEPTH_WIDTH      (AW),
        .c_ALMOST_FULL_NUM  (AF),
        .c_ALMOST_EMPTY_NUM (AE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .wr_data      (wr_data),
        .wr_en        (wr_en),
        .wr_vld       (wr_vld),
        .rd_data      (rd_data),
        .rd_en        (rd_en),
        .rd_vld       (rd_vld),
        .water_level  (water_level),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    // Each stored word remembers the edge that wrote it; it becomes visible two edges later.
    typedef struct {
        logic [DW-1:0] d;
        int            we;
    } ent_t;

    ent_t sbq[$];
    int   total = 0;
    int   bad = 0;
    int   ecount = 0;
    bit   m_ov = 1'b0;
    bit   m_un = 1'b0;
    bit   ev;
    bit   mfull;
    int   sz;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 50)
                $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) ecount <= ecount + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            sbq.delete();
            m_ov = 1'b0;
            m_un = 1'b0;
        end else begin
            sz    = sbq.size();
            mfull = (sz >= int'(DEPTH));
            ev    = 1'b0;
            if (sz > 0) ev = (sbq[0].we + 2 <= ecount);
            chk("rd_vld", {63'd0, rd_vld}, {63'd0, ev});
            if (ev) chk("rd_data", {32'd0, rd_data}, {32'd0, sbq[0].d});
            chk("wr_vld", {63'd0, wr_vld}, {63'd0, !mfull});
            chk("water_level", {{(63-AW){1'b0}}, water_level}, 64'(sz));
            chk("almost_full", {63'd0, almost_full}, {63'd0, sz >= int'(AF)});
            chk("almost_empty", {63'd0, almost_empty}, {63'd0, sz <= int'(AE)});
            chk("overflow", {63'd0, overflow}, {63'd0, m_ov});
            chk("underflow", {63'd0, underflow}, {63'd0, m_un});
            if (flush) begin
                sbq.delete();
                m_ov = 1'b0;
                m_un = 1'b0;
            end else begin
`ifdef IPML_PFIFO_ERR_FLAG_EN
                if (wr_en && mfull) m_ov = 1'b1;
                if (rd_en && !ev) m_un = 1'b1;
`endif
                if (rd_en && ev) void'(sbq.pop_front());
                if (wr_en && !mfull) sbq.push_back('{d: wr_data, we: ecount + 1});
            end
        end
    end

    task automatic drive(input bit we, input logic [DW-1:0] wd, input bit re, input bit fl);
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        flush   = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int unsigned wb;
        int unsigned rb;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_rd_data", {32'd0, rd_data}, 64'd0);
        @(posedge clk);
        #1;

        // single word first-word latency
        drive(1, 32'hA5A5_0001, 0, 0);
        repeat (4) drive(0, 0, 0, 0);
        repeat (2) drive(0, 0, 1, 0);

        // fill past full, then drain in order
        for (int i = 0; i <= int'(DEPTH); i++) drive(1, DW'(i), 0, 0);
        repeat (DEPTH + 4) drive(0, 0, 1, 0);

        // streaming write+read across several pointer wraps
        for (int i = 0; i < 3 * int'(DEPTH); i++) drive(1, DW'(32'h1000 + i), 1, 0);
        repeat (6) drive(0, 0, 1, 0);

        // almost_full / almost_empty thresholds
        for (int i = 0; i < int'(AF) + 1; i++) drive(1, DW'(32'h2000 + i), 0, 0);
        repeat (AF - AE + 2) drive(0, 0, 1, 0);
        drive(0, 0, 0, 1);

        // flush with a RAM read in flight
        for (int i = 0; i < 8; i++) drive(1, DW'(32'h3000 + i), 1, 0);
        drive(1, 32'hDEAD_BEEF, 1, 1);
        drive(1, 32'h0000_0777, 0, 0);
        repeat (3) drive(0, 0, 0, 0);
        repeat (3) drive(0, 0, 1, 0);

        // overflow / underflow stickiness and flush clear
        for (int i = 0; i < int'(DEPTH) + 3; i++) drive(1, DW'(32'h4000 + i), 0, 0);
        repeat (2) drive(0, 0, 0, 0);
        drive(0, 0, 0, 1);
        repeat (2) drive(0, 0, 1, 0);
        repeat (2) drive(0, 0, 0, 0);
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 0);

        // randomized traffic alternating fill-biased and drain-biased phases
        for (int i = 0; i < 3000; i++) begin
            wb = ((i / 400) % 2 == 1) ? 30 : 80;
            rb = ((i / 400) % 2 == 1) ? 80 : 35;
            drive($urandom_range(99) < wb, $urandom, $urandom_range(99) < rb, $urandom_range(249) == 0);
        end

        repeat (DEPTH + 6) drive(0, 0, 1, 0);
        repeat (3) drive(0, 0, 0, 0);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
